// File: rtl/gb_bus_pkg.sv
// Shared types for the bus sequencer: FSM states, bus owner and latched op.
package gb_bus_pkg;

  typedef enum logic [1:0] {
    ADDR   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    END    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

  // Read wins when the core raises both requests in the same M-cycle.
  function automatic op_t core_op(input logic rd, input logic we);
    if (rd) return OP_RD;
    if (we) return OP_WR;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/gb_tcycle_gen.sv
// T-cycle generator: phase counter that can be frozen, registered m_clk and
// phase flags used by the sequencer FSM.
module gb_tcycle_gen #(
  parameter int T_PER_M = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_hold,
  output logic [$clog2(T_PER_M)-1:0] o_t_phase,
  output logic                       o_m_clk,
  output logic                       o_is_first,
  output logic                       o_is_sample,
  output logic                       o_is_last
);
  localparam int TPW = $clog2(T_PER_M);

  logic [TPW-1:0] r_phase;
  logic           r_m_clk;
  logic [TPW-1:0] w_phase_next;

  // Advance and wrap the phase unless a wait state freezes it.
  always_comb begin
    w_phase_next = r_phase;
    if (!i_hold) begin
      if (r_phase == TPW'(T_PER_M - 1)) w_phase_next = '0;
      else                              w_phase_next = r_phase + TPW'(1);
    end
  end

  // m_clk is computed from the upcoming phase so it lines up with t_phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
      r_m_clk <= 1'b1;
    end else begin
      r_phase <= w_phase_next;
      r_m_clk <= (w_phase_next < TPW'(T_PER_M / 2));
    end
  end

  assign o_t_phase   = r_phase;
  assign o_m_clk     = r_m_clk;
  assign o_is_first  = (r_phase == '0);
  assign o_is_sample = (r_phase == TPW'(T_PER_M - 2));
  assign o_is_last   = (r_phase == TPW'(T_PER_M - 1));

endmodule

// File: rtl/gb_bus_sequencer.sv
// M-cycle sequencer and memory bus unit: one access per M-cycle, wait states
// with timeout, DMA takes the bus only at M-cycle boundaries.
module gb_bus_sequencer
  import gb_bus_pkg::*;
#(
  parameter int          AW       = 16,
  parameter int          DW       = 8,
  parameter int          T_PER_M  = 4,
  parameter int          MAX_WAIT = 15,
  parameter logic [AW-1:0] RST_ADDR = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       core_rd,
  input  logic                       core_we,
  input  logic [AW-1:0]              core_addr,
  input  logic [DW-1:0]              core_wdata,
  output logic [DW-1:0]              core_rdata,
  output logic [$clog2(T_PER_M)-1:0] t_phase,
  output logic                       m_clk,
  output logic                       m_end,
  output logic                       stall,
  output logic                       bus_err,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  output logic                       mem_rd,
  output logic                       mem_we,
  input  logic [DW-1:0]              mem_rdata,
  input  logic                       mem_ready,
  input  logic                       dma_req,
  input  logic                       dma_we,
  input  logic [AW-1:0]              dma_addr,
  input  logic [DW-1:0]              dma_wdata,
  output logic                       dma_gnt,
  output logic                       dma_done
);
  localparam int WCW = $clog2(MAX_WAIT + 2);

  state_t         r_state, w_state_next;
  logic           r_owner;
  op_t            r_op, w_op_new;
  logic [WCW-1:0] r_wait_cnt;
  logic           r_mem_rd, r_mem_we, r_bus_err;
  logic [DW-1:0]  r_core_rdata, r_mem_wdata;
  logic [AW-1:0]  r_mem_addr;
  logic           w_is_first, w_is_sample, w_is_last;
  logic           w_hold, w_ready_ok, w_wait_max, w_done, w_forced;

  gb_tcycle_gen #(.T_PER_M(T_PER_M)) u_tcycle (
    .clk        (clk),
    .rst        (rst),
    .i_hold     (w_hold),
    .o_t_phase  (t_phase),
    .o_m_clk    (m_clk),
    .o_is_first (w_is_first),
    .o_is_sample(w_is_sample),
    .o_is_last  (w_is_last)
  );

  // Idle cycles and zero-wait builds never stretch; otherwise memory decides.
  assign w_ready_ok = mem_ready || (MAX_WAIT == 0) || (r_op == OP_IDLE);
  assign w_wait_max = (r_wait_cnt == WCW'(MAX_WAIT));
  assign w_op_new   = (r_owner == OWN_DMA) ? (dma_we ? OP_WR : OP_RD)
                                           : core_op(core_rd, core_we);
  assign w_hold     = (w_state_next == WAIT);

  // Next-state logic; w_done/w_forced mark the edge that closes the access.
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_forced     = 1'b0;
    case (r_state)
      ADDR:   w_state_next = ACCESS;
      ACCESS: begin
        if (w_is_sample) begin
          if (w_ready_ok) begin
            w_state_next = END;
            w_done       = 1'b1;
          end else begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_ready) begin
          w_state_next = END;
          w_done       = 1'b1;
        end else if (w_wait_max) begin
          w_state_next = END;
          w_forced     = 1'b1;
        end
      end
      END:     w_state_next = ADDR;
      default: w_state_next = ADDR;
    endcase
  end

  // State, owner, address/data latches, strobes, wait counter and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ADDR;
      r_owner      <= OWN_CORE;
      r_op         <= OP_IDLE;
      r_wait_cnt   <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_bus_err    <= 1'b0;
      r_core_rdata <= '0;
      r_mem_addr   <= RST_ADDR;
      r_mem_wdata  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bus_err <= w_forced;
      if (w_is_first) begin
        r_mem_addr  <= (r_owner == OWN_DMA) ? dma_addr : core_addr;
        r_mem_wdata <= (r_owner == OWN_DMA) ? dma_wdata : core_wdata;
        r_op        <= w_op_new;
        r_wait_cnt  <= '0;
        r_mem_rd    <= (w_op_new == OP_RD);
        r_mem_we    <= (w_op_new == OP_WR);
      end
      if (w_state_next == WAIT) r_wait_cnt <= r_wait_cnt + WCW'(1);
      if (w_done || w_forced) begin
        r_mem_rd <= 1'b0;
        r_mem_we <= 1'b0;
        // DMA picks its read data straight off mem_rdata; only core reads land here.
        if (r_op == OP_RD && r_owner == OWN_CORE)
          r_core_rdata <= w_forced ? '1 : mem_rdata;
      end
      if (w_is_last) r_owner <= dma_req ? OWN_DMA : OWN_CORE;
    end
  end

  assign core_rdata = r_core_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_rd     = r_mem_rd;
  assign mem_we     = r_mem_we;
  assign bus_err    = r_bus_err;
  assign dma_gnt    = (r_owner == OWN_DMA);
  assign stall      = (r_state == WAIT) || (r_owner == OWN_DMA);
  assign m_end      = w_is_last && (r_owner == OWN_CORE);
  assign dma_done   = w_is_last && (r_owner == OWN_DMA);

endmodule
